// File: rtl/poly_pkg.sv
// Shared widths, default timeout and FSM state encoding for the polynomial
// sweep sequencer and its saturating Q24.8 adder.
package poly_pkg;

  localparam int unsigned Q_W             = 32;
  localparam int unsigned Y_W             = 128;
  localparam int unsigned IDX_W           = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_EMIT    = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/q24_8_sat_add.sv
// Combinational signed Q24.8 adder that clamps to the most positive/negative
// representable value and flags when clamping occurred.
module q24_8_sat_add
  import poly_pkg::*;
(
  input  logic [Q_W-1:0] a,
  input  logic [Q_W-1:0] b,
  output logic [Q_W-1:0] sum,
  output logic           sat
);

  logic [Q_W-1:0] raw_s;
  logic           ovf_s;

  // Signed overflow: operands share a sign that the raw sum does not.
  always_comb begin
    raw_s = a + b;
    ovf_s = (a[Q_W-1] == b[Q_W-1]) && (raw_s[Q_W-1] != a[Q_W-1]);
    sat   = ovf_s;
    if (ovf_s) begin
      if (a[Q_W-1]) begin
        sum = {1'b1, {(Q_W-1){1'b0}}};
      end else begin
        sum = {1'b0, {(Q_W-1){1'b1}}};
      end
    end else begin
      sum = raw_s;
    end
  end

endmodule

// File: rtl/poly_sweep_sequencer.sv
// Steps x across a sweep, drives the polynomial evaluator one point at a time
// and hands each result out through a single-entry valid/ready buffer.
module poly_sweep_sequencer
  import poly_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [Q_W-1:0]   cfg_x0,
  input  logic [Q_W-1:0]   cfg_step,
  input  logic [IDX_W-1:0] cfg_count,
  output logic             func_start,
  output logic [Q_W-1:0]   func_x,
  input  logic             func_done,
  input  logic [Y_W-1:0]   func_y,
  input  logic             func_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [Q_W-1:0]   res_x,
  output logic [Y_W-1:0]   res_y,
  output logic             res_ovf,
  output logic [IDX_W-1:0] res_idx,
  output logic             busy,
  output logic             sweep_done,
  output logic             x_sat,
  output logic             err_timeout
);

  state_t           state_r, state_nxt_s;
  logic [Q_W-1:0]   x_r, step_r, x_sum_s;
  logic [IDX_W-1:0] count_r, idx_r;
  logic [31:0]      to_cnt_r;
  logic             x_sum_sat_s, accepted_s, timeout_s, last_pt_s;
  logic             func_start_r, res_valid_r, res_ovf_r, busy_r;
  logic             sweep_done_r, x_sat_r, err_timeout_r;
  logic [Q_W-1:0]   res_x_r;
  logic [Y_W-1:0]   res_y_r;
  logic [IDX_W-1:0] res_idx_r;

  q24_8_sat_add u_sat_add (
    .a   (x_r),
    .b   (step_r),
    .sum (x_sum_s),
    .sat (x_sum_sat_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the result counts as accepted if already drained or taken this cycle.
  always_comb begin
    state_nxt_s = state_r;
    accepted_s  = !res_valid_r || res_ready;
    timeout_s   = (to_cnt_r == 32'(TIMEOUT_CYCLES - 1));
    last_pt_s   = ((idx_r + 16'd1) == count_r);
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_count != 16'd0) state_nxt_s = ST_ISSUE;
          else                    state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (func_done)      state_nxt_s = ST_RELEASE;
        else if (timeout_s) state_nxt_s = ST_FINISH;
        else                state_nxt_s = ST_WAIT;
      end
      ST_RELEASE: begin
        if (!func_done && accepted_s) state_nxt_s = ST_EMIT;
        else                          state_nxt_s = ST_RELEASE;
      end
      ST_EMIT: begin
        if (last_pt_s) state_nxt_s = ST_FINISH;
        else           state_nxt_s = ST_ISSUE;
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Sweep datapath, timeout counter and status flags; strobes follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r           <= 32'd0;
      step_r        <= 32'd0;
      count_r       <= 16'd0;
      idx_r         <= 16'd0;
      to_cnt_r      <= 32'd0;
      func_start_r  <= 1'b0;
      busy_r        <= 1'b0;
      sweep_done_r  <= 1'b0;
      x_sat_r       <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      func_start_r <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_WAIT);
      busy_r       <= (state_nxt_s != ST_IDLE);
      sweep_done_r <= (state_r == ST_FINISH);
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            x_r           <= cfg_x0;
            step_r        <= cfg_step;
            count_r       <= cfg_count;
            idx_r         <= 16'd0;
            x_sat_r       <= 1'b0;
            err_timeout_r <= 1'b0;
          end
        end
        ST_ISSUE: to_cnt_r <= 32'd0;
        ST_WAIT: begin
          if (!func_done && timeout_s) begin
            err_timeout_r <= 1'b1;
          end else if (!func_done) begin
            to_cnt_r <= to_cnt_r + 32'd1;
          end
        end
        // Only advance x when another point follows, so x_sat reflects issued points.
        ST_EMIT: begin
          if (!last_pt_s) begin
            idx_r <= idx_r + 16'd1;
            x_r   <= x_sum_s;
            if (x_sum_sat_s) x_sat_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Single-entry result buffer: loaded on func_done in WAIT, drained by res_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_x_r     <= 32'd0;
      res_y_r     <= 128'd0;
      res_ovf_r   <= 1'b0;
      res_idx_r   <= 16'd0;
    end else if ((state_r == ST_WAIT) && func_done) begin
      res_valid_r <= 1'b1;
      res_x_r     <= x_r;
      res_y_r     <= func_y;
      res_ovf_r   <= func_ovf;
      res_idx_r   <= idx_r;
    end else if (res_valid_r && res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  assign func_start  = func_start_r;
  assign func_x      = x_r;
  assign res_valid   = res_valid_r;
  assign res_x       = res_x_r;
  assign res_y       = res_y_r;
  assign res_ovf     = res_ovf_r;
  assign res_idx     = res_idx_r;
  assign busy        = busy_r;
  assign sweep_done  = sweep_done_r;
  assign x_sat       = x_sat_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: doc/poly_sweep_sequencer.md
POLY_SWEEP_SEQUENCER -- requirements
Module: poly_sweep_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles to wait for func_done per point.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_start  input  1  one-cycle pulse; starts a sweep.
REQ-005 SHALL have port cfg_x0  input  32  signed Q24.8 first x.
REQ-006 SHALL have port cfg_step  input  32  signed Q24.8 increment.
REQ-007 SHALL have port cfg_count  input  16  number of points.
REQ-008 SHALL have port func_start  output  1  to evaluator start_func.
REQ-009 SHALL have port func_x  output  32  to evaluator x_in, Q24.8.
REQ-010 SHALL have port func_done  input  1  from evaluator.
REQ-011 SHALL have port func_y  input  128  evaluator y_out, Q120.8.
REQ-012 SHALL have port func_ovf  input  1  evaluator overflow.
REQ-013 SHALL have port res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-014 SHALL have port res_x / res_y / res_ovf / res_idx  output  32 / 128 / 1 / 16  captured result.
REQ-015 SHALL have port busy, sweep_done, x_sat, err_timeout  output  1 each  status.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, WAIT, RELEASE, EMIT, FINISH.
REQ-017 IDLE: cfg_start samples cfg_x0/cfg_step/cfg_count; count>0 -> ISSUE; count==0 -> FINISH; cfg_start outside IDLE ignored.
REQ-018 ISSUE and WAIT: func_start=1, func_x = current x, stable; func_start rises cycle after cfg_start.
REQ-019 WAIT: func_done sampled 1 -> capture func_y, func_ovf, x, idx into result regs; next cycle func_start=0 and res_valid=1 (1-cycle capture latency); go RELEASE.
REQ-020 RELEASE: remain until func_done==0 and the result has been accepted; func_start low at least 1 cycle between points.
REQ-021 res_valid SHALL hold, payload stable, until res_ready sampled 1; single-entry buffer, no next ISSUE while res_valid=1.
REQ-022 After acceptance: idx+1; x = sat(x + step); idx==count -> FINISH else ISSUE.
REQ-023 Addition SHALL saturate to 0x7FFFFFFF / 0x80000000; any saturation sets sticky x_sat until next cfg_start accepted.
REQ-024 WAIT timeout: TIMEOUT_CYCLES cycles without func_done -> func_start=0, err_timeout=1 (sticky until next cfg_start), no result emitted, go FINISH.
REQ-025 FINISH: sweep_done=1 for exactly one cycle, then IDLE.
REQ-026 busy=1 in all states except IDLE.
REQ-027 res_idx SHALL be zero-based point index; res_ovf copies func_ovf at capture.
REQ-028 res_ready=1 in the same cycle res_valid rises completes the transfer that cycle.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and zero every output (func_start, func_x, res_*, busy, sweep_done, x_sat, err_timeout) on that edge.
REQ-030 Reset mid-sweep SHALL drop func_start immediately and discard pending result; no sweep_done generated.
REQ-031 After rst release, first cfg_start honoured on the first non-reset cycle.

Structure
REQ-032 Shared package poly_pkg SHALL hold Q24.8 width (32), Y width (128), idx width (16), FSM state enum, default timeout.
REQ-033 Saturating Q24.8 adder SHALL be sub-module q24_8_sat_add (combinational, outputs sum and sat flag).
REQ-034 Timeout counter and result register live in the top module.

Verification
REQ-035 x0=0, step=0x40, count=10, evaluator model done after 3 cycles, res_ready=1 -> 10 results, res_x 0x000..0x240 step 0x40, res_idx 0..9, one sweep_done.
REQ-036 Same sweep, res_ready low 5 cycles on point 2 -> res_valid held, payload stable, func_start low throughout stall, no point lost.
REQ-037 count=0 -> func_start never rises, sweep_done pulse 2 cycles after cfg_start.
REQ-038 x0=0x7FFFFF00, step=0x100, count=3 -> res_x 0x7FFFFF00, 0x7FFFFFFF, 0x7FFFFFFF; x_sat=1.
REQ-039 func_done stuck 0 -> after 1024 WAIT cycles err_timeout=1, func_start=0, sweep_done pulse, no res_valid.
REQ-040 rst=1 during WAIT of point 4 -> all outputs 0 on that edge; fresh sweep afterward starts at idx 0.
